// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair on the responder side of the state machine handshake.
// The two storage banks can be joined into one double-depth FIFO in either direction.
module pio_fifo_pair #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(2 * DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          join_tx,
  input  logic          join_rx,
  input  logic          host_tx_wen,
  input  logic [31:0]   host_tx_wdata,
  input  logic          host_rx_ren,
  output logic [31:0]   host_rx_rdata,
  input  logic          mach_pull,
  output logic [31:0]   mach_tx_data,
  output logic          mach_tx_empty,
  input  logic          mach_push,
  input  logic [31:0]   mach_rx_data,
  output logic          mach_rx_full,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  output logic          tx_full,
  output logic          rx_empty,
  output logic [3:0]    flags,
  input  logic [3:0]    flags_clr
);

  localparam int PW = $clog2(2 * DEPTH);
  localparam int BW = $clog2(DEPTH);
  localparam logic [LW-1:0] CAP_ONE = LW'(DEPTH);
  localparam logic [LW-1:0] CAP_TWO = LW'(2 * DEPTH);
  localparam logic [PW-1:0] BANK1_BASE = PW'(DEPTH);

  logic [31:0]   mem_r [0:2*DEPTH-1];
  logic [PW-1:0] tx_wr_r, tx_rd_r, rx_wr_r, rx_rd_r;
  logic [LW-1:0] tx_level_r, rx_level_r;
  logic [3:0]    flags_r;
  logic          join_tx_r, join_rx_r;

  logic          tx_join_s, rx_join_s, clear_s;
  logic [LW-1:0] tx_cap_s, rx_cap_s;
  logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic          tx_wr_s, tx_rd_s, rx_wr_s, rx_rd_s;
  logic [3:0]    flag_set_s;
  logic [PW-1:0] rx_wr_addr_s, rx_rd_addr_s;
  logic [LW-1:0] tx_level_nxt_s, rx_level_nxt_s;

  // Joined mode wraps across both banks; otherwise the pointer wraps within one bank.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr, input logic joined);
    logic [PW-1:0] nxt;
    if (joined) begin
      nxt = ptr + PW'(1);
    end else begin
      nxt = PW'(ptr[BW-1:0] + BW'(1));
    end
    return nxt;
  endfunction

  function automatic logic [LW-1:0] level_next(input logic [LW-1:0] lvl,
                                               input logic wr, input logic rd);
    logic [LW-1:0] nxt;
    case ({wr, rd})
      2'b10:   nxt = lvl + LW'(1);
      2'b01:   nxt = lvl - LW'(1);
      default: nxt = lvl;
    endcase
    return nxt;
  endfunction

  // Capacity, status flags, access qualification and error events.
  always_comb begin
    tx_join_s = join_tx_r & ~join_rx_r;
    rx_join_s = join_rx_r & ~join_tx_r;
    if (rx_join_s) begin
      tx_cap_s = LW'(0);
    end else if (tx_join_s) begin
      tx_cap_s = CAP_TWO;
    end else begin
      tx_cap_s = CAP_ONE;
    end
    if (tx_join_s) begin
      rx_cap_s = LW'(0);
    end else if (rx_join_s) begin
      rx_cap_s = CAP_TWO;
    end else begin
      rx_cap_s = CAP_ONE;
    end
    tx_empty_s = (tx_level_r == LW'(0));
    tx_full_s  = (tx_level_r == tx_cap_s);
    rx_empty_s = (rx_level_r == LW'(0));
    rx_full_s  = (rx_level_r == rx_cap_s);
    clear_s = flush | (join_tx != join_tx_r) | (join_rx != join_rx_r);

    tx_wr_s = host_tx_wen & ~tx_full_s & ~clear_s;
    tx_rd_s = mach_pull & ~tx_empty_s & ~clear_s;
    rx_wr_s = mach_push & ~rx_full_s & ~clear_s;
    rx_rd_s = host_rx_ren & ~rx_empty_s & ~clear_s;

    // A pop on an empty FIFO coinciding with an accepted write is silently ignored.
    flag_set_s[3] = host_rx_ren & rx_empty_s & ~rx_wr_s & ~clear_s;
    flag_set_s[2] = host_tx_wen & tx_full_s & ~clear_s;
    flag_set_s[1] = mach_push & rx_full_s & ~clear_s;
    flag_set_s[0] = mach_pull & tx_empty_s & ~tx_wr_s & ~clear_s;

    if (rx_join_s) begin
      rx_wr_addr_s = rx_wr_r;
      rx_rd_addr_s = rx_rd_r;
    end else begin
      rx_wr_addr_s = rx_wr_r + BANK1_BASE;
      rx_rd_addr_s = rx_rd_r + BANK1_BASE;
    end

    tx_level_nxt_s = level_next(tx_level_r, tx_wr_s, tx_rd_s);
    rx_level_nxt_s = level_next(rx_level_r, rx_wr_s, rx_rd_s);
  end

  // Pointer, level, flag and join-mode state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_r    <= '0;
      tx_rd_r    <= '0;
      rx_wr_r    <= '0;
      rx_rd_r    <= '0;
      tx_level_r <= '0;
      rx_level_r <= '0;
      flags_r    <= 4'b0000;
      join_tx_r  <= 1'b0;
      join_rx_r  <= 1'b0;
    end else if (clear_s) begin
      tx_wr_r    <= '0;
      tx_rd_r    <= '0;
      rx_wr_r    <= '0;
      rx_rd_r    <= '0;
      tx_level_r <= '0;
      rx_level_r <= '0;
      join_tx_r  <= join_tx;
      join_rx_r  <= join_rx;
    end else begin
      if (tx_wr_s) tx_wr_r <= ptr_next(tx_wr_r, tx_join_s);
      if (tx_rd_s) tx_rd_r <= ptr_next(tx_rd_r, tx_join_s);
      if (rx_wr_s) rx_wr_r <= ptr_next(rx_wr_r, rx_join_s);
      if (rx_rd_s) rx_rd_r <= ptr_next(rx_rd_r, rx_join_s);
      tx_level_r <= tx_level_nxt_s;
      rx_level_r <= rx_level_nxt_s;
      flags_r    <= (flags_r & ~flags_clr) | flag_set_s;
    end
  end

  // Shared storage; only one FIFO can address a given bank at a time.
  always_ff @(posedge clk) begin
    if (tx_wr_s) mem_r[tx_wr_r] <= host_tx_wdata;
    if (rx_wr_s) mem_r[rx_wr_addr_s] <= mach_rx_data;
  end

  assign mach_tx_data  = tx_empty_s ? 32'h0 : mem_r[tx_rd_r];
  assign host_rx_rdata = rx_empty_s ? 32'h0 : mem_r[rx_rd_addr_s];
  assign mach_tx_empty = tx_empty_s;
  assign tx_full       = tx_full_s;
  assign rx_empty      = rx_empty_s;
  assign mach_rx_full  = rx_full_s;
  assign tx_level      = tx_level_r;
  assign rx_level      = rx_level_r;
  assign flags         = flags_r;

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed bench for pio_fifo_pair: popped words are checked by a scoreboard monitor,
// status (levels, flags, empty/full) by inline comparisons.
module tb_pio_fifo_pair;
  localparam int DEPTH = 4;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset, flush, join_tx, join_rx;
  logic host_tx_wen, host_rx_ren, mach_pull, mach_push;
  logic [31:0] host_tx_wdata, host_rx_rdata, mach_tx_data, mach_rx_data;
  logic mach_tx_empty, mach_rx_full, tx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;
  logic [3:0] flags, flags_clr;

  int checks = 0;
  int errors = 0;
  logic [31:0] tx_exp[$];
  logic [31:0] rx_exp[$];

  pio_fifo_pair #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .join_tx(join_tx), .join_rx(join_rx),
    .host_tx_wen(host_tx_wen), .host_tx_wdata(host_tx_wdata),
    .host_rx_ren(host_rx_ren), .host_rx_rdata(host_rx_rdata),
    .mach_pull(mach_pull), .mach_tx_data(mach_tx_data), .mach_tx_empty(mach_tx_empty),
    .mach_push(mach_push), .mach_rx_data(mach_rx_data), .mach_rx_full(mach_rx_full),
    .tx_level(tx_level), .rx_level(rx_level), .tx_full(tx_full), .rx_empty(rx_empty),
    .flags(flags), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pop happens whenever the strobe meets a non-empty FIFO.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (mach_pull && !mach_tx_empty) begin
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_pop_unexpected: got %0h expected none", mach_tx_data);
        end else begin
          logic [31:0] e;
          e = tx_exp.pop_front();
          if (mach_tx_data !== e) begin
            errors++;
            $display("FAIL tx_pop_data: got %0h expected %0h", mach_tx_data, e);
          end
        end
      end
      if (host_rx_ren && !rx_empty) begin
        checks++;
        if (rx_exp.size() == 0) begin
          errors++;
          $display("FAIL rx_pop_unexpected: got %0h expected none", host_rx_rdata);
        end else begin
          logic [31:0] e;
          e = rx_exp.pop_front();
          if (host_rx_rdata !== e) begin
            errors++;
            $display("FAIL rx_pop_data: got %0h expected %0h", host_rx_rdata, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; join_tx = 1'b0; join_rx = 1'b0;
    host_tx_wen = 1'b0; host_tx_wdata = 32'h0; host_rx_ren = 1'b0;
    mach_pull = 1'b0; mach_push = 1'b0; mach_rx_data = 32'h0; flags_clr = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_tx_level", 32'(tx_level), 32'd0);
    chk("rst_rx_level", 32'(rx_level), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_tx_empty", 32'(mach_tx_empty), 32'd1);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_tx_data", mach_tx_data, 32'h0);
    chk("rst_rx_data", host_rx_rdata, 32'h0);

    // TX fill, overflow, drain
    for (int i = 0; i < 4; i++) begin
      host_tx_wen = 1'b1;
      host_tx_wdata = 32'h11 * 32'(i + 1);
      tx_exp.push_back(host_tx_wdata);
      tick();
      chk("tx_fill_level", 32'(tx_level), 32'(i + 1));
    end
    chk("tx_full_after_fill", 32'(tx_full), 32'd1);
    host_tx_wdata = 32'h55;
    tick();
    host_tx_wen = 1'b0;
    chk("tx_overflow", 32'(flags), 32'b0100);
    chk("tx_level_after_ovf", 32'(tx_level), 32'd4);
    mach_pull = 1'b1;
    repeat (4) tick();
    mach_pull = 1'b0;
    chk("tx_drained_empty", 32'(mach_tx_empty), 32'd1);
    chk("tx_drained_data", mach_tx_data, 32'h0);
    chk("tx_no_stall_on_drain", 32'(flags), 32'b0100);
    flags_clr = 4'b0100;
    tick();
    flags_clr = 4'b0000;
    chk("ovf_cleared", 32'(flags), 32'd0);

    // Blocking pull on empty TX, clear, clear-vs-set priority
    mach_pull = 1'b1;
    repeat (3) tick();
    mach_pull = 1'b0;
    chk("tx_stall_set", 32'(flags), 32'b0001);
    chk("tx_stall_level", 32'(tx_level), 32'd0);
    flags_clr = 4'b0001;
    tick();
    flags_clr = 4'b0000;
    chk("tx_stall_cleared", 32'(flags), 32'd0);
    flags_clr = 4'b0001; mach_pull = 1'b1;
    tick();
    flags_clr = 4'b0000; mach_pull = 1'b0;
    chk("set_wins_over_clr", 32'(flags), 32'b0001);
    flags_clr = 4'b0001;
    tick();
    flags_clr = 4'b0000;

    // RX fill, stall, drain, underflow
    mach_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mach_rx_data = 32'hA0 + 32'(i);
      rx_exp.push_back(mach_rx_data);
      tick();
    end
    mach_rx_data = 32'hA4;
    tick();
    mach_push = 1'b0;
    chk("rx_stall", 32'(flags), 32'b0010);
    chk("rx_level_full", 32'(rx_level), 32'd4);
    chk("rx_full_flag", 32'(mach_rx_full), 32'd1);
    host_rx_ren = 1'b1;
    repeat (4) tick();
    chk("rx_empty_data", host_rx_rdata, 32'h0);
    chk("rx_empty_flag", 32'(rx_empty), 32'd1);
    tick();
    host_rx_ren = 1'b0;
    chk("rx_underflow", 32'(flags), 32'b1010);
    flags_clr = 4'b1111;
    tick();
    flags_clr = 4'b0000;

    // Joined RX: 8 entries, TX has zero capacity
    join_rx = 1'b1;
    tick();
    chk("join_tx_empty", 32'(mach_tx_empty), 32'd1);
    chk("join_tx_full", 32'(tx_full), 32'd1);
    chk("join_tx_level", 32'(tx_level), 32'd0);
    mach_push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mach_rx_data = 32'hB0 + 32'(i);
      rx_exp.push_back(mach_rx_data);
      tick();
      if (i == 6) chk("join_rx_not_full_at7", 32'(mach_rx_full), 32'd0);
    end
    mach_push = 1'b0;
    chk("join_rx_full", 32'(mach_rx_full), 32'd1);
    chk("join_rx_level", 32'(rx_level), 32'd8);
    chk("join_no_stall", 32'(flags), 32'd0);
    host_tx_wen = 1'b1; host_tx_wdata = 32'hDEAD;
    tick();
    host_tx_wen = 1'b0;
    chk("join_tx_overflow", 32'(flags), 32'b0100);
    chk("join_tx_level_after", 32'(tx_level), 32'd0);
    host_rx_ren = 1'b1;
    repeat (8) tick();
    host_rx_ren = 1'b0;
    join_rx = 1'b0;
    tick();
    flags_clr = 4'b1111;
    tick();
    flags_clr = 4'b0000;
    chk("unjoin_flags_clear", 32'(flags), 32'd0);

    // Full TX: write + pull, write dropped
    host_tx_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_tx_wdata = 32'h61 + 32'(i);
      tx_exp.push_back(host_tx_wdata);
      tick();
    end
    host_tx_wdata = 32'h99; mach_pull = 1'b1;
    tick();
    host_tx_wen = 1'b0; mach_pull = 1'b0;
    chk("full_wp_level", 32'(tx_level), 32'd3);
    chk("full_wp_ovf", 32'(flags), 32'b0100);
    mach_pull = 1'b1;
    repeat (3) tick();
    mach_pull = 1'b0;
    chk("full_wp_drained", 32'(mach_tx_empty), 32'd1);
    flags_clr = 4'b1111;
    tick();
    flags_clr = 4'b0000;

    // Empty TX: write + pull, write lands, no stall
    host_tx_wen = 1'b1; host_tx_wdata = 32'h77; mach_pull = 1'b1;
    tick();
    host_tx_wen = 1'b0; mach_pull = 1'b0;
    chk("empty_wp_flags", 32'(flags), 32'd0);
    chk("empty_wp_level", 32'(tx_level), 32'd1);
    chk("empty_wp_head", mach_tx_data, 32'h77);
    tx_exp.push_back(32'h77);
    mach_pull = 1'b1;
    tick();
    mach_pull = 1'b0;

    // Flush mid-stream keeps flags
    mach_pull = 1'b1;
    tick();
    mach_pull = 1'b0;
    host_tx_wen = 1'b1; mach_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_tx_wdata = 32'hC0 + 32'(i);
      mach_rx_data = 32'hD0 + 32'(i);
      if (i == 2) host_tx_wen = 1'b0;
      tick();
    end
    mach_push = 1'b0;
    chk("pre_flush_tx_level", 32'(tx_level), 32'd2);
    chk("pre_flush_rx_level", 32'(rx_level), 32'd3);
    flush = 1'b1; host_tx_wen = 1'b1; host_tx_wdata = 32'hEE;
    tick();
    flush = 1'b0; host_tx_wen = 1'b0;
    chk("flush_tx_level", 32'(tx_level), 32'd0);
    chk("flush_rx_level", 32'(rx_level), 32'd0);
    chk("flush_flags_kept", 32'(flags), 32'b0001);
    chk("flush_tx_data", mach_tx_data, 32'h0);

    // Async reset between edges
    host_tx_wen = 1'b1; host_tx_wdata = 32'hE0;
    tick();
    host_tx_wen = 1'b0;
    chk("pre_reset_tx_level", 32'(tx_level), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tx_level", 32'(tx_level), 32'd0);
    chk("async_rst_tx_empty", 32'(mach_tx_empty), 32'd1);
    chk("async_rst_tx_data", mach_tx_data, 32'h0);
    chk("async_rst_flags", 32'(flags), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    chk("tx_scoreboard_drained", 32'(tx_exp.size()), 32'd0);
    chk("rx_scoreboard_drained", 32'(rx_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pio_fifo_pair.md
Name: pio_fifo_pair

Overview:
- Responder side of the state machine's FIFO handshake.
- Holds the TX FIFO, which the host writes and the machine pulls.
- Holds the RX FIFO, which the machine pushes and the host reads.
- Supports joining both storage banks into one double-depth FIFO in either direction.
- Presents first-word-fall-through data and combinational empty/full flags to the machine, plus level and sticky-error status to the host.
- One instance per state machine, inside the PIO top level.

Parameters:
- DEPTH, 4, entries per bank; power of two ≥ 2. Joined FIFO depth = 2*DEPTH.
- LW, $clog2(2*DEPTH)+1, width of the level outputs.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of both FIFOs (driven on SM restart)
- join_tx  in  1  TX uses both banks
- join_rx  in  1  RX uses both banks
- host_tx_wen  in  1  host write strobe
- host_tx_wdata  in  32  host write data
- host_rx_ren  in  1  host read strobe
- host_rx_rdata  out  32  RX head word (FWFT)
- mach_pull  in  1  machine pull strobe
- mach_tx_data  out  32  TX head word (FWFT) to machine din
- mach_tx_empty  out  1  TX empty
- mach_push  in  1  machine push strobe
- mach_rx_data  in  32  machine dout
- mach_rx_full  out  1  RX full
- tx_level  out  LW  TX occupancy
- rx_level  out  LW  RX occupancy
- tx_full  out  1  TX full (host status)
- rx_empty  out  1  RX empty (host status)
- flags  out  4  sticky {rx_underflow, tx_overflow, rx_stall, tx_stall}
- flags_clr  in  4  write-1-to-clear for flags, same bit order

Behaviour:
- Capacity:
  - join_tx only: TX = 2*DEPTH, RX = 0.
  - join_rx only: RX = 2*DEPTH, TX = 0.
  - Neither or both set: DEPTH each.
- Zero-capacity FIFO: reads as permanently empty and full (empty=1, full=1, level=0). All accesses are rejected and set the corresponding error flag.
- Reset (async): both FIFOs empty, levels 0, flags 0, data outputs 0.
- Empty data outputs: when a FIFO is empty its data output = 0. Storage contents are otherwise don't-care.
- Status timing:
  - Flags and levels are registered; they reflect state at the start of the cycle.
  - empty = (level==0), full = (level==capacity).
- Write accept rules (evaluated per cycle from start-of-cycle flags):
  - TX write is accepted iff host_tx_wen & !tx_full.
  - RX write is accepted iff mach_push & !mach_rx_full.
- Pop rules:
  - TX pop on mach_pull & !mach_tx_empty.
  - RX pop on host_rx_ren & !rx_empty.
- Popped word:
  - It is the data output value in that same cycle; zero-cycle read latency.
  - The next head appears the following cycle.
- Write visibility: a written word becomes visible at the head one cycle after the write if the FIFO was empty. Write-to-read latency = 1.
- Same-FIFO simultaneous write and pop:
  - Both are legal when the flags allow; level is unchanged.
  - Full + write + pop: the write is rejected (overflow/stall flag set) and the pop proceeds.
  - Empty + write + pop: the pop is ignored (no flag) and the write proceeds.
- Error flags (sticky until cleared):
  - Rejected host TX write → tx_overflow.
  - Host RX read while empty → rx_underflow; host_rx_rdata = 0.
  - mach_pull while empty → tx_stall. A blocking pull holds pull high for many cycles; the flag just stays set.
  - mach_push while full → rx_stall.
- flags_clr:
  - Clears the selected bits next edge.
  - A set event in the same cycle wins over the clear.
- Pointers: read/write pointers wrap modulo capacity, with separate wrap handling for DEPTH and 2*DEPTH. Level is kept as a counter, not derived from pointers.
- Flush, or any change of join_tx/join_rx (detected against a registered copy):
  - Empties both FIFOs next edge; levels go to 0.
  - All accesses in that cycle are discarded.
  - flags are unchanged.
- Reset asserted mid-operation: immediate clear, no partial writes.

Test Plan:
- Reset, then host writes 0x11, 0x22, 0x33, 0x44 (DEPTH=4) → tx_level 1..4, tx_full=1. A fifth write of 0x55 is dropped and tx_overflow=1. mach_pull for 4 cycles yields 0x11, 0x22, 0x33, 0x44, then mach_tx_empty=1 and mach_tx_data=0.
- mach_pull held high 3 cycles on empty TX → no pop, tx_stall=1. flags_clr=0001 → tx_stall=0 next cycle. Simultaneous clear and new stall → flag stays 1.
- Machine pushes 0xA0..0xA3, then 0xA4 → rx_stall=1 and rx_level=4. Host reads yield 0xA0..0xA3. A fifth read returns 0 and sets rx_underflow=1.
- join_rx=1 → both FIFOs flushed. RX accepts 8 pushes (0xB0..0xB7) before mach_rx_full=1. TX has mach_tx_empty=1 and tx_full=1; a host write sets tx_overflow.
- TX full: host write 0x99 + mach_pull in the same cycle → head pops, 0x99 is dropped, tx_overflow=1, tx_level=3. TX empty: write 0x77 + pull in the same cycle → write lands, no stall, 0x77 at head next cycle.
- Mid-stream: levels TX=2, RX=3, then pulse flush → both levels 0 next cycle, flags unchanged. Assert reset asynchronously between edges → outputs clear immediately.
